user_obi_copy_mgr: RTL and testbench

// - User-domain OBI manager: word-granular memory copy engine, initiator counterpart to the user subordinates (ROM, setbitacc).
// - Configured through its own OBI subordinate port at UserCopyAddrOffset; moves LEN 32-bit words SRC->DST on its OBI manager port into the main crossbar.
// - Strictly one outstanding transaction; completion and errors reported in STATUS.

---
 rtl/user_obi_copy_mgr_pkg.sv | 114 +++++++++++
 rtl/user_obi_copy_mgr_regs.sv | 117 +++++++++++
 rtl/user_obi_copy_mgr.sv | 154 +++++++++++++++
 tb/tb_user_obi_copy_mgr.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_obi_copy_mgr_pkg.sv
// Shared types and constants for the user-domain OBI copy manager:
// bus structs, user-domain address map entries, register indices and FSM states.
package user_obi_copy_mgr_pkg;

    localparam int unsigned SbrIdW = 2;
    localparam int unsigned MgrIdW = 1;

    // User-domain address map
    localparam logic [31:0] UserBaseAddr = 32'h2000_0000;

    typedef enum logic [1:0] {
        UserError     = 2'd0,
        UserRom       = 2'd1,
        UserSetBitAcc = 2'd2,
        UserCopy      = 2'd3
    } user_demux_outputs_e;

    localparam int unsigned NumUserDomainSubordinates = 3;
    localparam logic [31:0] UserCopyAddrOffset = UserBaseAddr + 32'h0000_2000;
    localparam logic [31:0] UserCopyAddrRange  = 32'h0000_1000;
    localparam int unsigned NumUserDomainManagers = 1;
    localparam int unsigned UserCopyMgr = 0;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    localparam addr_rule_t UserCopyRule = '{
        idx:        32'd3,
        start_addr: UserCopyAddrOffset,
        end_addr:   UserCopyAddrOffset + UserCopyAddrRange
    };

    // Register word indices (address bits [11:2] inside the config window)
    localparam logic [9:0] RegSrcIdx    = 10'd0;
    localparam logic [9:0] RegDstIdx    = 10'd1;
    localparam logic [9:0] RegLenIdx    = 10'd2;
    localparam logic [9:0] RegCtrlIdx   = 10'd3;
    localparam logic [9:0] RegStatusIdx = 10'd4;

    typedef enum logic [2:0] {
        CopyIdle   = 3'd0,
        CopyRdReq  = 3'd1,
        CopyRdWait = 3'd2,
        CopyWrReq  = 3'd3,
        CopyWrWait = 3'd4
    } copy_state_e;

    // Config (subordinate) port structs
    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic [SbrIdW-1:0] aid;
    } sbr_obi_a_t;

    typedef struct packed {
        logic       req;
        sbr_obi_a_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic [SbrIdW-1:0] rid;
        logic              err;
    } sbr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        sbr_obi_r_t r;
    } sbr_obi_rsp_t;

    // Copy-traffic (manager) port structs
    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic [MgrIdW-1:0] aid;
    } mgr_obi_a_t;

    typedef struct packed {
        logic       req;
        mgr_obi_a_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic [MgrIdW-1:0] rid;
        logic              err;
    } mgr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        mgr_obi_r_t r;
    } mgr_obi_rsp_t;

    // Merge a write into an existing word honouring the byte enables
    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_obi_copy_mgr_regs.sv
// Config-port register file of the copy manager: decode, SRC/DST/LEN storage,
// CTRL start/clear pulses and STATUS readback with a one-cycle response.
module user_obi_copy_regs
    import user_obi_copy_mgr_pkg::*;
#(
    parameter type sbr_obi_req_t = user_obi_copy_mgr_pkg::sbr_obi_req_t,
    parameter type sbr_obi_rsp_t = user_obi_copy_mgr_pkg::sbr_obi_rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t sbr_req_i,
    output sbr_obi_rsp_t sbr_rsp_o,
    input  logic         busy_i,
    input  logic         done_i,
    input  logic         err_i,
    input  logic [15:0]  words_i,
    output logic [31:0]  src_o,
    output logic [31:0]  dst_o,
    output logic [15:0]  len_o,
    output logic         start_o,
    output logic         clear_o
);

    logic [31:0]  src_q, src_d;
    logic [31:0]  dst_q, dst_d;
    logic [15:0]  len_q, len_d;
    sbr_obi_rsp_t rsp_q, rsp_d;
    logic [9:0]   word_idx_s;
    logic [31:0]  len_wide_s;
    logic [31:0]  rdata_s;
    logic         unused_addr_s;

    assign word_idx_s    = sbr_req_i.a.addr[11:2];
    assign unused_addr_s = ^{sbr_req_i.a.addr[31:12], sbr_req_i.a.addr[1:0]};

    // Register writes and CTRL pulse generation; config registers freeze while busy
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        start_o    = 1'b0;
        clear_o    = 1'b0;
        len_wide_s = apply_be({16'h0000, len_q}, sbr_req_i.a.wdata, sbr_req_i.a.be);
        if (sbr_req_i.req && sbr_req_i.a.we) begin
            case (word_idx_s)
                RegSrcIdx: begin
                    if (!busy_i) src_d = apply_be(src_q, sbr_req_i.a.wdata, sbr_req_i.a.be);
                    else         src_d = src_q;
                end
                RegDstIdx: begin
                    if (!busy_i) dst_d = apply_be(dst_q, sbr_req_i.a.wdata, sbr_req_i.a.be);
                    else         dst_d = dst_q;
                end
                RegLenIdx: begin
                    if (!busy_i) len_d = len_wide_s[15:0];
                    else         len_d = len_q;
                end
                RegCtrlIdx: begin
                    start_o = sbr_req_i.a.be[0] & sbr_req_i.a.wdata[0] & ~busy_i;
                    clear_o = sbr_req_i.a.be[0] & sbr_req_i.a.wdata[1];
                end
                default: begin
                    start_o = 1'b0;
                end
            endcase
        end else begin
            start_o = 1'b0;
        end
    end

    // Readback mux and response captured for the cycle after the grant
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (sbr_req_i.req && !sbr_req_i.a.we) begin
            case (word_idx_s)
                RegSrcIdx:    rdata_s = src_q;
                RegDstIdx:    rdata_s = dst_q;
                RegLenIdx:    rdata_s = {16'h0000, len_q};
                RegStatusIdx: rdata_s = {words_i, 13'h0000, err_i, done_i, busy_i};
                default:      rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
        rsp_d          = '0;
        rsp_d.rvalid   = sbr_req_i.req;
        rsp_d.r.rdata  = rdata_s;
        rsp_d.r.rid    = sbr_req_i.a.aid;
        rsp_d.r.err    = 1'b0;
    end

    // Register state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q <= 32'h0000_0000;
            dst_q <= 32'h0000_0000;
            len_q <= 16'h0000;
            rsp_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            rsp_q <= rsp_d;
        end
    end

    // Grant is immediate; everything else comes from the registered response
    always_comb begin
        sbr_rsp_o     = rsp_q;
        sbr_rsp_o.gnt = sbr_req_i.req;
    end

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign len_o = len_q;

endmodule

// File: rtl/user_obi_copy_mgr.sv
// User-domain OBI copy manager: copies LEN words SRC->DST, one outstanding
// transaction at a time, with completion/error flags driving a level interrupt.
module user_obi_copy_mgr
    import user_obi_copy_mgr_pkg::*;
#(
    parameter type sbr_obi_req_t = user_obi_copy_mgr_pkg::sbr_obi_req_t,
    parameter type sbr_obi_rsp_t = user_obi_copy_mgr_pkg::sbr_obi_rsp_t,
    parameter type mgr_obi_req_t = user_obi_copy_mgr_pkg::mgr_obi_req_t,
    parameter type mgr_obi_rsp_t = user_obi_copy_mgr_pkg::mgr_obi_rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t sbr_req_i,
    output sbr_obi_rsp_t sbr_rsp_o,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    output logic         irq_o
);

    copy_state_e state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] src_s, dst_s, rd_addr_s, wr_addr_s;
    logic [15:0] len_s, idx_inc_s;
    logic        start_s, clear_s, busy_s;
    logic        unused_s;

    assign busy_s    = (state_q != CopyIdle);
    assign idx_inc_s = idx_q + 16'd1;
    assign rd_addr_s = {src_s[31:2], 2'b00} + {14'h0000, idx_q, 2'b00};
    assign wr_addr_s = {dst_s[31:2], 2'b00} + {14'h0000, idx_q, 2'b00};
    assign unused_s  = ^{src_s[1:0], dst_s[1:0], mgr_rsp_i.r.rid};

    user_obi_copy_regs #(
        .sbr_obi_req_t (sbr_obi_req_t),
        .sbr_obi_rsp_t (sbr_obi_rsp_t)
    ) i_regs (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sbr_req_i (sbr_req_i),
        .sbr_rsp_o (sbr_rsp_o),
        .busy_i    (busy_s),
        .done_i    (done_q),
        .err_i     (err_q),
        .words_i   (idx_q),
        .src_o     (src_s),
        .dst_o     (dst_s),
        .len_o     (len_s),
        .start_o   (start_s),
        .clear_o   (clear_s)
    );

    // Copy FSM: next state, datapath updates and manager-port request decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        mgr_req_o = '0;
        if (clear_s) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            done_d = done_q;
        end
        case (state_q)
            CopyIdle: begin
                if (start_s) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idx_d  = 16'h0000;
                    if (len_s == 16'h0000) done_d  = 1'b1;
                    else                   state_d = CopyRdReq;
                end else begin
                    state_d = CopyIdle;
                end
            end
            CopyRdReq: begin
                mgr_req_o.req    = 1'b1;
                mgr_req_o.a.addr = rd_addr_s;
                mgr_req_o.a.we   = 1'b0;
                mgr_req_o.a.be   = 4'hF;
                if (mgr_rsp_i.gnt) state_d = CopyRdWait;
                else               state_d = CopyRdReq;
            end
            CopyRdWait: begin
                if (mgr_rsp_i.rvalid) begin
                    data_d = mgr_rsp_i.r.rdata;
                    if (mgr_rsp_i.r.err) begin
                        err_d   = 1'b1;
                        state_d = CopyIdle;
                    end else begin
                        state_d = CopyWrReq;
                    end
                end else begin
                    state_d = CopyRdWait;
                end
            end
            CopyWrReq: begin
                mgr_req_o.req     = 1'b1;
                mgr_req_o.a.addr  = wr_addr_s;
                mgr_req_o.a.we    = 1'b1;
                mgr_req_o.a.be    = 4'hF;
                mgr_req_o.a.wdata = data_q;
                if (mgr_rsp_i.gnt) state_d = CopyWrWait;
                else               state_d = CopyWrReq;
            end
            CopyWrWait: begin
                if (mgr_rsp_i.rvalid) begin
                    if (mgr_rsp_i.r.err) begin
                        err_d   = 1'b1;
                        state_d = CopyIdle;
                    end else begin
                        idx_d = idx_inc_s;
                        if (idx_inc_s == len_s) begin
                            done_d  = 1'b1;
                            state_d = CopyIdle;
                        end else begin
                            state_d = CopyRdReq;
                        end
                    end
                end else begin
                    state_d = CopyWrWait;
                end
            end
            default: begin
                state_d = CopyIdle;
            end
        endcase
    end

    // FSM and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CopyIdle;
            idx_q   <= 16'h0000;
            data_q  <= 32'h0000_0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign irq_o = done_q | err_q;

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Scoreboard bench for user_obi_copy_mgr: a memory model answers the manager
// port with random stalls/delays, expected bus transactions and config
// responses are queued by a reference model and checked by monitors.
module tb_user_obi_copy_mgr;
    import user_obi_copy_mgr_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_txn_t;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic [1:0]  rid;
    } cfg_exp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    sbr_obi_req_t sbr_req;
    sbr_obi_rsp_t sbr_rsp;
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp;
    logic         irq;

    int vectors = 0;
    int miscompares = 0;

    bus_txn_t bus_exp_q[$];
    cfg_exp_t cfg_exp_q[$];
    bit [31:0] bus_mem [bit [31:0]];
    bit [31:0] ref_mem [bit [31:0]];

    // reference model of the programmer-visible state
    logic [31:0] m_src = 32'h0, m_dst = 32'h0;
    logic [15:0] m_len = 16'h0, m_words = 16'h0;
    logic        m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;

    // bus responder knobs / state
    int max_stall = 0, max_delay = 1;
    int err_read_at = -1;
    int rd_cnt = 0, wr_cnt = 0, req_seen = 0;
    bit hold_writes = 1'b0;
    int rsp_wait = 0, stall_left = 0;
    bit tracking = 1'b0;
    mgr_obi_a_t held;
    logic [31:0] pend_rdata;
    logic        pend_err;

    user_obi_copy_mgr dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp),
        .mgr_req_o (mgr_req),
        .mgr_rsp_i (mgr_rsp),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return seed_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        if (be[0]) r[7:0]   = n[7:0];
        if (be[1]) r[15:8]  = n[15:8];
        if (be[2]) r[23:16] = n[23:16];
        if (be[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    function automatic logic [31:0] model_reg(input logic [9:0] idx);
        case (idx)
            RegSrcIdx:    return m_src;
            RegDstIdx:    return m_dst;
            RegLenIdx:    return {16'h0, m_len};
            RegStatusIdx: return {m_words, 13'h0, m_err, m_done, m_busy};
            default:      return 32'h0;
        endcase
    endfunction

    // Manager-port memory: random grant stalls, response delays, error injection
    initial begin
        mgr_rsp = '0;
        forever begin
            @(negedge clk);
            mgr_rsp = '0;
            if (mgr_req.req) req_seen++;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    mgr_rsp.rvalid  = 1'b1;
                    mgr_rsp.r.rdata = pend_rdata;
                    mgr_rsp.r.err   = pend_err;
                end
            end else if (mgr_req.req) begin
                if (!tracking) begin
                    tracking   = 1'b1;
                    stall_left = int'($urandom_range(max_stall, 0));
                    held       = mgr_req.a;
                end else begin
                    chk("stall_addr", mgr_req.a.addr, held.addr);
                    chk("stall_we", {31'h0, mgr_req.a.we}, {31'h0, held.we});
                    chk("stall_wdata", mgr_req.a.wdata, held.wdata);
                end
                if (stall_left == 0 && !(hold_writes && mgr_req.a.we)) begin
                    bus_txn_t e;
                    mgr_rsp.gnt = 1'b1;
                    tracking    = 1'b0;
                    chk("mgr_aid", {31'h0, mgr_req.a.aid}, 32'h0);
                    chk("mgr_be", {28'h0, mgr_req.a.be}, 32'hF);
                    if (bus_exp_q.size() == 0) begin
                        chk("unexpected_txn_addr", mgr_req.a.addr, 32'hFFFF_FFFF);
                    end else begin
                        e = bus_exp_q.pop_front();
                        chk("txn_addr", mgr_req.a.addr, e.addr);
                        chk("txn_we", {31'h0, mgr_req.a.we}, {31'h0, e.we});
                        if (e.we) chk("txn_wdata", mgr_req.a.wdata, e.wdata);
                    end
                    if (mgr_req.a.we) begin
                        bus_mem[mgr_req.a.addr] = mgr_req.a.wdata;
                        pend_err = 1'b0;
                        wr_cnt++;
                    end else begin
                        pend_err = (rd_cnt == err_read_at);
                        rd_cnt++;
                    end
                    pend_rdata = bus_rd(mgr_req.a.addr);
                    rsp_wait   = int'($urandom_range(max_delay, 1));
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end else begin
                tracking = 1'b0;
            end
        end
    end

    // Config-port monitor: every rvalid pops one expected response
    always @(negedge clk) begin
        if (sbr_rsp.rvalid) begin
            if (cfg_exp_q.size() == 0) begin
                chk("cfg_unexpected_rvalid", 32'h1, 32'h0);
            end else begin
                cfg_exp_t e;
                e = cfg_exp_q.pop_front();
                chk("cfg_rid", {30'h0, sbr_rsp.r.rid}, {30'h0, e.rid});
                chk("cfg_err", {31'h0, sbr_rsp.r.err}, 32'h0);
                if (e.chk_data) chk("cfg_rdata", sbr_rsp.r.rdata, e.data);
            end
        end
    end

    task automatic cfg_drive(input logic [9:0] idx, input logic we, input logic [31:0] wd,
                             input logic [3:0] be, input logic chk_data, input logic [31:0] exp);
        logic [1:0] aid;
        cfg_exp_t   e;
        aid = 2'($urandom_range(3, 0));
        e.chk_data = chk_data;
        e.data     = exp;
        e.rid      = aid;
        cfg_exp_q.push_back(e);
        @(negedge clk);
        sbr_req.req     = 1'b1;
        sbr_req.a.addr  = UserCopyAddrOffset + {20'h0, idx, 2'b00};
        sbr_req.a.we    = we;
        sbr_req.a.be    = be;
        sbr_req.a.wdata = wd;
        sbr_req.a.aid   = aid;
        #1;
        chk("cfg_gnt", {31'h0, sbr_rsp.gnt}, 32'h1);
        @(negedge clk);
        sbr_req = '0;
    endtask

    task automatic cfg_write(input logic [9:0] idx, input logic [31:0] wd, input logic [3:0] be);
        if (!m_busy) begin
            case (idx)
                RegSrcIdx: m_src = merge(m_src, wd, be);
                RegDstIdx: m_dst = merge(m_dst, wd, be);
                RegLenIdx: begin
                    logic [31:0] t;
                    t = merge({16'h0, m_len}, wd, be);
                    m_len = t[15:0];
                end
                default: ;
            endcase
        end
        cfg_drive(idx, 1'b1, wd, be, 1'b0, 32'h0);
    endtask

    task automatic cfg_read(input logic [9:0] idx);
        cfg_drive(idx, 1'b0, 32'h0, 4'hF, 1'b1, model_reg(idx));
    endtask

    // Plan the expected word-by-word copy, start it, optionally wait and check
    task automatic run_copy(input int err_idx, input bit wait_done, output int cycles);
        int       words;
        bit       e_err;
        bus_txn_t t;
        words = 0;
        e_err = 1'b0;
        cycles = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        err_read_at = err_idx;
        for (int i = 0; i < int'(m_len); i++) begin
            logic [31:0] a, w, d;
            a = (m_src & 32'hFFFF_FFFC) + (32'(i) << 2);
            d = ref_rd(a);
            t.addr = a; t.we = 1'b0; t.wdata = 32'h0;
            bus_exp_q.push_back(t);
            if (i == err_idx) begin
                e_err = 1'b1;
                break;
            end
            w = (m_dst & 32'hFFFF_FFFC) + (32'(i) << 2);
            t.addr = w; t.we = 1'b1; t.wdata = d;
            bus_exp_q.push_back(t);
            ref_mem[w] = d;
            words++;
        end
        cfg_write(RegCtrlIdx, 32'h1, 4'hF);
        m_done = 1'b0;
        m_err  = 1'b0;
        m_busy = (m_len != 16'h0);
        if (wait_done) begin
            while (!irq && cycles < 5000) begin
                @(negedge clk);
                cycles++;
            end
            chk("irq_after_copy", {31'h0, irq}, 32'h1);
            m_busy  = 1'b0;
            m_done  = !e_err;
            m_err   = e_err;
            m_words = 16'(words);
            chk("bus_txns_left", bus_exp_q.size(), 32'h0);
            chk("words_written", wr_cnt, words);
            for (int i = 0; i < words; i++) begin
                logic [31:0] w;
                w = (m_dst & 32'hFFFF_FFFC) + (32'(i) << 2);
                chk("dst_word", bus_rd(w), ref_rd(w));
            end
            cfg_read(RegStatusIdx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        sbr_req = '0;
        rst_i   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mgr_req", {31'h0, mgr_req.req}, 32'h0);
        chk("rst_sbr_rvalid", {31'h0, sbr_rsp.rvalid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst_i = 1'b0;
        for (int r = 0; r < 6; r++) cfg_read(10'(r));
        cfg_read(10'h3FF);

        // Directed zero-wait copy of four preloaded words
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, v;
            a = 32'h1000_0000 + 32'(i * 4);
            v = 32'h1111_1111 * 32'(i + 1);
            bus_mem[a] = v;
            ref_mem[a] = v;
        end
        cfg_write(RegSrcIdx, 32'h1000_0000, 4'hF);
        cfg_write(RegDstIdx, 32'h1000_0100, 4'hF);
        cfg_write(RegLenIdx, 32'h0000_0004, 4'hF);
        run_copy(-1, 1'b1, cyc);
        chk("zero_wait_cycles", cyc, 16);
        for (int i = 0; i < 4; i++)
            chk("copied_word", bus_rd(32'h1000_0100 + 32'(i * 4)), 32'h1111_1111 * 32'(i + 1));

        // Partial byte-enable write and unmapped readback
        cfg_write(RegDstIdx, 32'hAABB_CCDD, 4'b0101);
        cfg_read(RegDstIdx);
        cfg_read(RegCtrlIdx);

        // Clear, then LEN=0 start: done next cycle, no bus traffic
        cfg_write(RegCtrlIdx, 32'h2, 4'hF);
        m_done = 1'b0;
        m_err  = 1'b0;
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        cfg_write(RegLenIdx, 32'h0, 4'hF);
        seen = req_seen;
        run_copy(-1, 1'b0, cyc);
        chk("len0_irq", {31'h0, irq}, 32'h1);
        m_done  = 1'b1;
        m_words = 16'h0;
        repeat (5) @(negedge clk);
        chk("len0_no_req", req_seen, seen);
        cfg_read(RegStatusIdx);

        // Randomised copies under grant stalls and response delays
        max_stall = 5;
        max_delay = 5;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] s, d;
            s = 32'h1000_0000 + {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            s[1:0] = 2'($urandom_range(3, 0));
            d = 32'h1000_0000 + {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            cfg_write(RegSrcIdx, s, 4'hF);
            cfg_write(RegDstIdx, d, 4'hF);
            cfg_write(RegLenIdx, 32'($urandom_range(8, 1)), 4'hF);
            cfg_read(RegSrcIdx);
            run_copy(-1, 1'b1, cyc);
        end

        // Read error on word 2 of four
        cfg_write(RegSrcIdx, 32'h1000_0000, 4'hF);
        cfg_write(RegDstIdx, 32'h1000_0300, 4'hF);
        cfg_write(RegLenIdx, 32'h4, 4'hF);
        run_copy(2, 1'b1, cyc);
        chk("err_two_writes", wr_cnt, 2);

        // Source wrapping through the top of the address space
        cfg_write(RegSrcIdx, 32'hFFFF_FFF8, 4'hF);
        cfg_write(RegDstIdx, 32'h1000_0200, 4'hF);
        run_copy(-1, 1'b1, cyc);

        // Reset during a stalled write; SRC write while busy is ignored
        hold_writes = 1'b1;
        cfg_write(RegSrcIdx, 32'h1000_0040, 4'hF);
        run_copy(-1, 1'b0, cyc);
        cyc = 0;
        while (!(mgr_req.req && mgr_req.a.we) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("wr_stall_reached", {31'h0, mgr_req.req & mgr_req.a.we}, 32'h1);
        cfg_write(RegSrcIdx, 32'hDEAD_BEE0, 4'hF);
        cfg_read(RegSrcIdx);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("post_rst_req", {31'h0, mgr_req.req}, 32'h0);
        chk("post_rst_irq", {31'h0, irq}, 32'h0);
        bus_exp_q.delete();
        ref_mem = bus_mem;
        hold_writes = 1'b0;
        m_src = 32'h0; m_dst = 32'h0; m_len = 16'h0;
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_words = 16'h0;
        cfg_read(RegStatusIdx);
        cfg_read(RegSrcIdx);
        repeat (10) @(negedge clk);
        chk("post_rst_no_req", {31'h0, mgr_req.req}, 32'h0);
        chk("cfg_rsp_left", cfg_exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
